// File: rtl/simulador_reservatorios.sv
// simulador_reservatorios: behavioural plant model of a two-tank water system
// (lower cistern feeding an upper tank through a pump). Levels advance once
// per prescaled tick, saturate at 0 and NIVEL_MAX, and raise sticky
// dry-run / overflow flags. Outputs are active-low level sensors per tank.
//
// Build option: define SIM_CONSUMO_EN to let the consumo input drain the
// upper tank. Without it consumo is ignored and the upper tank never falls.
module simulador_reservatorios #(
  parameter int QUARTO        = 16,
  parameter int MARGEM        = 4,
  parameter int DIV_TICK      = 1000,
  parameter int VAZAO_ENTRADA = 3,
  parameter int VAZAO_BOMBA   = 2,
  parameter int CONSUMO       = 1,
  localparam int NIVEL_MAX    = 4 * QUARTO + MARGEM,
  localparam int W            = $clog2(NIVEL_MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bomba,
  input  logic         valvula,
  input  logic         consumo,
  input  logic         carga,
  input  logic [W-1:0] nivel_inf_ini,
  input  logic [W-1:0] nivel_sup_ini,
  output logic [4:0]   sensores_inf,
  output logic [4:0]   sensores_sup,
  output logic [W-1:0] nivel_inf,
  output logic [W-1:0] nivel_sup,
  output logic         bomba_seco,
  output logic         transbordo
);

  // Two extra bits give headroom for inf+e and a sign for sup-c.
  localparam int SW = W + 2;
  localparam int CW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;

  localparam logic signed [SW-1:0] MAX_S = SW'(NIVEL_MAX);
  localparam logic signed [SW-1:0] VB_S  = SW'(VAZAO_BOMBA);
  localparam logic signed [SW-1:0] VE_S  = SW'(VAZAO_ENTRADA);
  localparam logic [W-1:0]         MAX_U = W'(NIVEL_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  inf_q, inf_d, sup_q, sup_d;
  logic          seco_q, seco_d, transb_q, transb_d;
  logic          tick;

  logic signed [SW-1:0] inf_s, sup_s, head_s, t_s, e_s, c_s, inf_raw, sup_raw;

`ifdef SIM_CONSUMO_EN
  localparam logic signed [SW-1:0] CO_S = SW'(CONSUMO);
`else
  logic unused_consumo;
  assign unused_consumo = consumo;
`endif

  assign tick = (cnt_q == CW'(DIV_TICK - 1));

  // Level update terms, all computed from pre-tick values.
  always_comb begin
    inf_s  = $signed({2'b00, inf_q});
    sup_s  = $signed({2'b00, sup_q});
    head_s = MAX_S - sup_s;
    t_s    = '0;
    if (bomba) begin
      t_s = VB_S;
      if (inf_s < t_s)  t_s = inf_s;
      if (head_s < t_s) t_s = head_s;
    end
    e_s = valvula ? VE_S : '0;
`ifdef SIM_CONSUMO_EN
    c_s = consumo ? CO_S : '0;
`else
    c_s = '0;
`endif
    inf_raw = inf_s - t_s + e_s;
    sup_raw = sup_s + t_s - c_s;
  end

  // Next-state selection: preset beats tick, tick beats hold.
  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    inf_d    = inf_q;
    sup_d    = sup_q;
    seco_d   = seco_q;
    transb_d = transb_q;
    if (carga) begin
      cnt_d = '0;
      inf_d = (nivel_inf_ini > MAX_U) ? MAX_U : nivel_inf_ini;
      sup_d = (nivel_sup_ini > MAX_U) ? MAX_U : nivel_sup_ini;
    end else if (tick) begin
      cnt_d = '0;
      inf_d = (inf_raw > MAX_S) ? MAX_U : inf_raw[W-1:0];
      sup_d = (sup_raw < 0) ? '0 : sup_raw[W-1:0];
      if (inf_raw > MAX_S)        transb_d = 1'b1;
      if (bomba && (inf_q == '0)) seco_d   = 1'b1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      inf_q    <= '0;
      sup_q    <= '0;
      seco_q   <= 1'b0;
      transb_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      inf_q    <= inf_d;
      sup_q    <= sup_d;
      seco_q   <= seco_d;
      transb_q <= transb_d;
    end
  end

  function automatic logic [4:0] decode(input logic [W-1:0] l);
    decode[0] = ~(l >= W'(QUARTO));
    decode[1] = ~(l >= W'(2 * QUARTO));
    decode[2] = ~(l >= W'(3 * QUARTO));
    decode[3] = ~(l >= W'(4 * QUARTO));
    decode[4] = ~(l >= MAX_U);
  endfunction

  // Combinational sensor decode straight from the level registers.
  always_comb begin
    sensores_inf = decode(inf_q);
    sensores_sup = decode(sup_q);
  end

  assign nivel_inf  = inf_q;
  assign nivel_sup  = sup_q;
  assign bomba_seco = seco_q;
  assign transbordo = transb_q;

endmodule

// File: tb/tb_simulador_reservatorios.sv
// Directed bench for simulador_reservatorios with QUARTO=4, MARGEM=2
// (NIVEL_MAX=18), DIV_TICK=4. Inputs change on negedge, outputs are read
// #1 after a posedge.
module tb_simulador_reservatorios;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         bomba, valvula, consumo, carga;
  logic [W-1:0] nivel_inf_ini, nivel_sup_ini;
  logic [4:0]   sensores_inf, sensores_sup;
  logic [W-1:0] nivel_inf, nivel_sup;
  logic         bomba_seco, transbordo;

  int assert_count = 0;
  int fail_count   = 0;

  simulador_reservatorios #(
    .QUARTO(4), .MARGEM(2), .DIV_TICK(4),
    .VAZAO_ENTRADA(3), .VAZAO_BOMBA(2), .CONSUMO(1)
  ) dut (
    .clk(clk), .reset(reset), .bomba(bomba), .valvula(valvula),
    .consumo(consumo), .carga(carga),
    .nivel_inf_ini(nivel_inf_ini), .nivel_sup_ini(nivel_sup_ini),
    .sensores_inf(sensores_inf), .sensores_sup(sensores_sup),
    .nivel_inf(nivel_inf), .nivel_sup(nivel_sup),
    .bomba_seco(bomba_seco), .transbordo(transbordo)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: preset levels and commands; counter is cleared at the carga edge.
  task automatic do_preset(input logic [W-1:0] li, input logic [W-1:0] ls,
                           input logic b, input logic v, input logic c);
    @(negedge clk);
    carga = 1'b1; nivel_inf_ini = li; nivel_sup_ini = ls;
    bomba = b; valvula = v; consumo = c;
    @(posedge clk);
    @(negedge clk);
    carga = 1'b0;
  endtask

  task automatic wait_tick();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bomba = 0; valvula = 0; consumo = 0; carga = 0;
    nivel_inf_ini = '0; nivel_sup_ini = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    assert_count++;
    if (sensores_inf !== 5'b11111 || sensores_sup !== 5'b11111) begin
      fail_count++;
      $display("FAIL reset_sensors: got inf=%b sup=%b, want 11111 11111", sensores_inf, sensores_sup);
    end
    assert_count++;
    if (nivel_inf !== 5'd0 || nivel_sup !== 5'd0 || bomba_seco !== 1'b0 || transbordo !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_state: got inf=%0d sup=%0d seco=%b transb=%b, want 0 0 0 0",
               nivel_inf, nivel_sup, bomba_seco, transbordo);
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] exp_lvl [7] = '{5'd3, 5'd6, 5'd9, 5'd12, 5'd15, 5'd18, 5'd18};
    logic [4:0]   exp_sen [7] = '{5'b11111, 5'b11110, 5'b11100, 5'b11000,
                                  5'b11000, 5'b00000, 5'b00000};
    do_preset(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    // Between ticks nothing moves.
    repeat (3) @(posedge clk);
    #1;
    assert_count++;
    if (nivel_inf !== 5'd0) begin
      fail_count++;
      $display("FAIL fill_pre_tick: got inf=%0d, want 0", nivel_inf);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) wait_tick();
      assert_count++;
      if (nivel_inf !== exp_lvl[i] || sensores_inf !== exp_sen[i] ||
          transbordo !== (i == 6)) begin
        fail_count++;
        $display("FAIL fill_tick%0d: got inf=%0d sen=%b transb=%b, want %0d %b %b",
                 i + 1, nivel_inf, sensores_inf, transbordo, exp_lvl[i], exp_sen[i], i == 6);
      end
    end
  endtask

  task automatic test_pump();
    logic [W-1:0] exp_inf [4] = '{5'd3, 5'd1, 5'd0, 5'd0};
    logic [W-1:0] exp_sup [4] = '{5'd2, 5'd4, 5'd5, 5'd5};
    do_preset(5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    assert_count++;
    if (nivel_inf !== 5'd5 || transbordo !== 1'b1) begin
      fail_count++;
      $display("FAIL preset_keeps_flag: got inf=%0d transb=%b, want 5 1", nivel_inf, transbordo);
    end
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      assert_count++;
      if (nivel_inf !== exp_inf[i] || nivel_sup !== exp_sup[i] || bomba_seco !== (i == 3)) begin
        fail_count++;
        $display("FAIL pump_tick%0d: got (%0d,%0d) seco=%b, want (%0d,%0d) %b",
                 i + 1, nivel_inf, nivel_sup, bomba_seco, exp_inf[i], exp_sup[i], i == 3);
      end
    end
  endtask

  task automatic test_headroom();
    do_preset(5'd10, 5'd17, 1'b1, 1'b0, 1'b0);
    wait_tick();
    assert_count++;
    if (nivel_inf !== 5'd9 || nivel_sup !== 5'd18 || sensores_sup !== 5'b00000) begin
      fail_count++;
      $display("FAIL headroom: got inf=%0d sup=%0d sen_sup=%b, want 9 18 00000",
               nivel_inf, nivel_sup, sensores_sup);
    end
  endtask

  task automatic test_consumo();
`ifdef SIM_CONSUMO_EN
    logic [W-1:0] exp_sup [4] = '{5'd2, 5'd1, 5'd0, 5'd0};
`else
    logic [W-1:0] exp_sup [4] = '{5'd3, 5'd3, 5'd3, 5'd3};
`endif
    do_preset(5'd0, 5'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      assert_count++;
      if (nivel_sup !== exp_sup[i]) begin
        fail_count++;
        $display("FAIL consumo_tick%0d: got sup=%0d, want %0d", i + 1, nivel_sup, exp_sup[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_preset(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    wait_tick();
    assert_count++;
    if (nivel_inf !== 5'd3) begin
      fail_count++;
      $display("FAIL midreset_pre: got inf=%0d, want 3", nivel_inf);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    assert_count++;
    if (nivel_inf !== 5'd0 || sensores_inf !== 5'b11111 || bomba_seco !== 1'b0 || transbordo !== 1'b0) begin
      fail_count++;
      $display("FAIL midreset_async: got inf=%0d sen=%b seco=%b transb=%b, want 0 11111 0 0",
               nivel_inf, sensores_inf, bomba_seco, transbordo);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    assert_count++;
    if (nivel_inf !== 5'd0) begin
      fail_count++;
      $display("FAIL midreset_no_early_tick: got inf=%0d, want 0", nivel_inf);
    end
    @(posedge clk);
    #1;
    assert_count++;
    if (nivel_inf !== 5'd3) begin
      fail_count++;
      $display("FAIL midreset_first_tick: got inf=%0d, want 3", nivel_inf);
    end
  endtask

  task automatic test_carga_vs_tick();
    do_preset(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);   // counter now at its tick value
    @(negedge clk);
    carga = 1'b1; nivel_inf_ini = 5'd7; nivel_sup_ini = 5'd31;
    @(posedge clk);
    #1;
    assert_count++;
    if (nivel_inf !== 5'd7 || nivel_sup !== 5'd18) begin
      fail_count++;
      $display("FAIL carga_priority: got (%0d,%0d), want (7,18)", nivel_inf, nivel_sup);
    end
    @(negedge clk);
    carga = 1'b0;
    wait_tick();
    assert_count++;
    if (nivel_inf !== 5'd10 || nivel_sup !== 5'd18 || sensores_sup !== 5'b00000) begin
      fail_count++;
      $display("FAIL carga_then_tick: got (%0d,%0d) sen_sup=%b, want (10,18) 00000",
               nivel_inf, nivel_sup, sensores_sup);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pump();
    test_headroom();
    test_consumo();
    test_mid_reset();
    test_carga_vs_tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  // Safety bound in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
